// File: rtl/des_key_sched_seq_if.sv
// Handshake bundle for the iterative DES key scheduler.
// Key offer side, round-key stream side and status flags travel together.
interface des_key_sched_seq_if #(
    parameter int IDX_W = 4
);
    logic [63:0]      key_in;
    logic             decrypt;
    logic             key_valid;
    logic             key_ready;
    logic             flush;
    logic [47:0]      rk_out;
    logic [IDX_W-1:0] rk_idx;
    logic             rk_valid;
    logic             rk_ready;
    logic             rk_last;
    logic             busy;
    logic             parity_err;

    // Key source / round-key consumer
    modport master (
        output key_in, decrypt, key_valid, flush, rk_ready,
        input  key_ready, rk_out, rk_idx, rk_valid, rk_last, busy, parity_err
    );

    // Scheduler
    modport slave (
        input  key_in, decrypt, key_valid, flush, rk_ready,
        output key_ready, rk_out, rk_idx, rk_valid, rk_last, busy, parity_err
    );
endinterface

// File: rtl/des_key_sched_seq.sv
// Iterative DES round-key scheduler: one shared rotate + PC-2 datapath,
// streams ROUNDS round keys per accepted key, forward or reverse order.
// Optional macro DES_KEY_PARITY_CHK_EN adds the odd-parity check per key byte.
module des_key_sched_seq #(
    parameter int ROUNDS = 16,  // 1..16, first ROUNDS entries of the shift schedule
    parameter int IDX_W  = 4    // 2**IDX_W >= ROUNDS
) (
    input  logic               clk,
    input  logic               rst_n,
    des_key_sched_seq_if.slave bus
);

    // DES bit numbers, bit 1 = MSB of the source vector
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Left-shift amount of round n (1-based); out-of-range rounds never get used
    function automatic logic [4:0] shift_of(input int n);
        return (n == 1 || n == 2 || n == 9 || n == 16) ? 5'd1 : 5'd2;
    endfunction

    function automatic int shift_sum(input int n);
        int s;
        s = 0;
        for (int i = 1; i <= n; i++) s += int'(shift_of(i));
        return s;
    endfunction

    // Decrypt jumps straight to C_ROUNDS/D_ROUNDS; 16 rounds wrap to identity
    localparam int         S_TOT    = shift_sum(ROUNDS) % 28;
    localparam logic [4:0] LOAD_DEC = 5'(S_TOT);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(ROUNDS - 1);

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int j = 0; j < 56; j++) r[55-j] = k[64-PC1_T[j]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2_T[j]];
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
        logic [55:0] t;
        t = {x, x} << n;
        return t[55:28];
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [4:0] n);
        logic [55:0] t;
        t = {x, x} >> n;
        return t[27:0];
    endfunction

    typedef enum logic {IDLE, EMIT} state_t;

    typedef struct packed {
        logic [47:0]      rk;
        logic [IDX_W-1:0] idx;
        logic             last;
    } rsp_t;

    state_t      state_q;
    logic [27:0] c_q, d_q;
    logic        dec_q;
    rsp_t        rsp_q;
    logic        valid_q;
    logic        key_ready_q;
    logic        busy_q;

    logic             xfer;
    logic             adv;
    logic [55:0]      cd0;
    logic [4:0]       sh;
    logic [27:0]      c_d, d_d;
    logic [IDX_W-1:0] idx_d;
    logic             last_d;
    logic [47:0]      rk_d;

    // Next C/D, index and last flag for either a key load or an accepted beat
    always_comb begin
        cd0    = pc1(bus.key_in);
        xfer   = bus.key_valid & key_ready_q & ~bus.flush;
        adv    = valid_q & bus.rk_ready & ~rsp_q.last & ~bus.flush;
        sh     = '0;
        c_d    = c_q;
        d_d    = d_q;
        idx_d  = rsp_q.idx;
        last_d = rsp_q.last;
        if (xfer) begin
            sh     = bus.decrypt ? LOAD_DEC : shift_of(1);
            c_d    = rotl28(cd0[55:28], sh);
            d_d    = rotl28(cd0[27:0], sh);
            idx_d  = bus.decrypt ? IDX_END : '0;
            last_d = (ROUNDS == 1);
        end else if (adv) begin
            if (dec_q) begin
                sh     = shift_of(int'(rsp_q.idx) + 1);
                c_d    = rotr28(c_q, sh);
                d_d    = rotr28(d_q, sh);
                idx_d  = rsp_q.idx - IDX_W'(1);
                last_d = (idx_d == '0);
            end else begin
                sh     = shift_of(int'(rsp_q.idx) + 2);
                c_d    = rotl28(c_q, sh);
                d_d    = rotl28(d_q, sh);
                idx_d  = rsp_q.idx + IDX_W'(1);
                last_d = (idx_d == IDX_END);
            end
        end
        rk_d = pc2({c_d, d_d});
    end

    // Control FSM with registered handshake outputs; flush beats everything but reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c_q         <= '0;
            d_q         <= '0;
            dec_q       <= 1'b0;
            rsp_q       <= '0;
            valid_q     <= 1'b0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            rsp_q.idx   <= '0;
            rsp_q.last  <= 1'b0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_q     <= EMIT;
                        c_q         <= c_d;
                        d_q         <= d_d;
                        dec_q       <= bus.decrypt;
                        rsp_q       <= '{rk: rk_d, idx: idx_d, last: last_d};
                        valid_q     <= 1'b1;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                EMIT: begin
                    if (valid_q & bus.rk_ready) begin
                        if (rsp_q.last) begin
                            state_q     <= IDLE;
                            valid_q     <= 1'b0;
                            rsp_q.last  <= 1'b0;
                            key_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            c_q   <= c_d;
                            d_q   <= d_d;
                            rsp_q <= '{rk: rk_d, idx: idx_d, last: last_d};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DES_KEY_PARITY_CHK_EN
    logic par_bad;
    logic perr_q;

    // Any key byte with even parity flags the key
    always_comb begin
        par_bad = 1'b0;
        for (int k = 0; k < 8; k++) par_bad = par_bad | ~(^bus.key_in[8*k +: 8]);
    end

    // Flag is sampled per key and held for the whole sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        perr_q <= 1'b0;
        else if (bus.flush) perr_q <= 1'b0;
        else if (xfer)     perr_q <= par_bad;
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.key_ready = key_ready_q;
    assign bus.rk_out    = rsp_q.rk;
    assign bus.rk_idx    = rsp_q.idx;
    assign bus.rk_last   = rsp_q.last;
    assign bus.rk_valid  = valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Scoreboard bench for des_key_sched_seq: a 16-round and a 1-round instance.
module tb_des_key_sched_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef DES_KEY_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // Published K1..K16 for key 133457799BBCDFF1
    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };
    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_AP = 64'h133457799BBCDFF0;
    localparam logic [63:0] KEY_Z  = 64'h0101010101010101;

    des_key_sched_seq_if #(.IDX_W(4)) bus ();
    des_key_sched_seq_if #(.IDX_W(1)) bus1 ();

    des_key_sched_seq #(.ROUNDS(16), .IDX_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    des_key_sched_seq #(.ROUNDS(1), .IDX_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    typedef struct {
        logic [47:0] rk;
        int          idx;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t sb1[$];
    exp_t e, e1;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the 16-round instance: stall stability and in-order beats
    logic        stall_q = 1'b0;
    logic [47:0] st_rk;
    logic [3:0]  st_idx;
    always @(negedge clk) begin
        if (rst_n && bus.rk_valid) begin
            if (stall_q) begin
                check("stall_rk", 64'(bus.rk_out), 64'(st_rk));
                check("stall_idx", 64'(bus.rk_idx), 64'(st_idx));
            end
            if (bus.rk_ready) begin
                if (sb.size() == 0) begin
                    check("extra_beat_idx", 64'(bus.rk_idx), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("rk_out", 64'(bus.rk_out), 64'(e.rk));
                    check("rk_idx", 64'(bus.rk_idx), 64'(e.idx));
                    check("rk_last", 64'(bus.rk_last), 64'(e.last));
                end
                stall_q = 1'b0;
            end else begin
                stall_q = 1'b1;
                st_rk   = bus.rk_out;
                st_idx  = bus.rk_idx;
            end
        end else begin
            stall_q = 1'b0;
        end
    end

    // Monitor for the 1-round instance
    always @(negedge clk) begin
        if (rst_n && bus1.rk_valid && bus1.rk_ready) begin
            if (sb1.size() == 0) begin
                check("r1_extra_beat", 64'(bus1.rk_out), 64'hFFFF);
            end else begin
                e1 = sb1.pop_front();
                check("r1_rk_out", 64'(bus1.rk_out), 64'(e1.rk));
                check("r1_rk_idx", 64'(bus1.rk_idx), 64'(e1.idx));
                check("r1_rk_last", 64'(bus1.rk_last), 64'(e1.last));
            end
        end
    end

    // Queue the first n beats of a 16-round stream, zero keys for the weak key
    task automatic push_seq(input bit dec, input int n, input bit zero);
        int i;
        for (int j = 0; j < n; j++) begin
            i = dec ? 15 - j : j;
            sb.push_back('{rk: zero ? 48'h0 : KS[i], idx: i, last: dec ? (i == 0) : (i == 15)});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge
    task automatic send_key(input logic [63:0] k, input bit dec);
        check("key_ready_idle", 64'(bus.key_ready), 64'h1);
        bus.key_in    = k;
        bus.decrypt   = dec;
        bus.key_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        int n;
        n = 0;
        while (bus.key_ready !== 1'b1 && n < budget) begin
            if (rnd) bus.rk_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        check("done_in_budget", 64'(n < budget), 64'h1);
        bus.rk_ready = 1'b1;
    endtask

    task automatic run_r1(input bit dec);
        sb1.push_back('{rk: KS[0], idx: 0, last: 1'b1});
        bus1.key_in    = KEY_A;
        bus1.decrypt   = dec;
        bus1.key_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.key_valid = 1'b0;
        check("r1_valid", 64'(bus1.rk_valid), 64'h1);
        check("r1_key_ready_low", 64'(bus1.key_ready), 64'h0);
        @(posedge clk);
        #1;
        check("r1_key_ready_back", 64'(bus1.key_ready), 64'h1);
        check("r1_valid_drop", 64'(bus1.rk_valid), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        bus.key_in = '0;  bus.decrypt = 1'b0;  bus.key_valid = 1'b0;
        bus.flush = 1'b0; bus.rk_ready = 1'b1;
        bus1.key_in = '0; bus1.decrypt = 1'b0; bus1.key_valid = 1'b0;
        bus1.flush = 1'b0; bus1.rk_ready = 1'b1;

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.rk_valid), 64'h0);
        check("rst_last", 64'(bus.rk_last), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_perr", 64'(bus.parity_err), 64'h0);
        check("rst_rk_out", 64'(bus.rk_out), 64'h0);
        check("rst_rk_idx", 64'(bus.rk_idx), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_key_ready", 64'(bus.key_ready), 64'h1);

        // Encrypt with rk_ready high: 16 consecutive beats then key_ready
        push_seq(1'b0, 16, 1'b0);
        send_key(KEY_A, 1'b0);
        check("perr_good_key", 64'(bus.parity_err), 64'h0);
        for (int i = 0; i < 16; i++) begin
            check("enc_consec_valid", 64'(bus.rk_valid), 64'h1);
            check("enc_key_ready_low", 64'(bus.key_ready), 64'h0);
            check("enc_busy", 64'(bus.busy), 64'h1);
            @(posedge clk);
            #1;
        end
        check("enc_key_ready_back", 64'(bus.key_ready), 64'h1);
        check("enc_valid_drop", 64'(bus.rk_valid), 64'h0);
        check("enc_busy_drop", 64'(bus.busy), 64'h0);

        // Decrypt: exact reverse stream
        push_seq(1'b1, 16, 1'b0);
        send_key(KEY_A, 1'b1);
        check("dec_first_idx", 64'(bus.rk_idx), 64'd15);
        wait_done(1'b0, 40);

        // Random backpressure, key offers during EMIT ignored; parity-bad key
        push_seq(1'b0, 16, 1'b0);
        send_key(KEY_AP, 1'b0);
        check("perr_bad_key", 64'(bus.parity_err), 64'(PAR_EN));
        bus.key_in    = KEY_Z;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.rk_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("busy_key_ready_low", 64'(bus.key_ready), 64'h0);
        end
        bus.key_valid = 1'b0;
        wait_done(1'b1, 400);
        check("perr_held", 64'(bus.parity_err), 64'(PAR_EN));

        // Weak key: all round keys zero, parity good clears the flag
        push_seq(1'b0, 16, 1'b1);
        send_key(KEY_Z, 1'b0);
        check("perr_cleared", 64'(bus.parity_err), 64'h0);
        wait_done(1'b0, 40);

        // Flush on beat 7 while stalled
        push_seq(1'b0, 6, 1'b0);
        send_key(KEY_A, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("flush_pending_idx", 64'(bus.rk_idx), 64'd6);
        bus.rk_ready = 1'b0;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_valid", 64'(bus.rk_valid), 64'h0);
        check("flush_key_ready", 64'(bus.key_ready), 64'h1);
        check("flush_idx", 64'(bus.rk_idx), 64'h0);
        check("flush_last", 64'(bus.rk_last), 64'h0);
        check("flush_busy", 64'(bus.busy), 64'h0);
        check("flush_sb_empty", 64'(sb.size()), 64'h0);
        bus.rk_ready = 1'b1;
        push_seq(1'b0, 16, 1'b0);
        send_key(KEY_A, 1'b0);
        wait_done(1'b0, 40);

        // flush with key_valid in IDLE: key not taken
        bus.key_in    = KEY_A;
        bus.key_valid = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.flush     = 1'b0;
        check("flush_idle_key_ready", 64'(bus.key_ready), 64'h1);
        check("flush_idle_valid", 64'(bus.rk_valid), 64'h0);
        check("flush_idle_busy", 64'(bus.busy), 64'h0);

        // Reset after 5 accepted beats
        push_seq(1'b0, 5, 1'b0);
        send_key(KEY_A, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.rk_valid), 64'h0);
        check("mid_rst_rk_out", 64'(bus.rk_out), 64'h0);
        check("mid_rst_rk_idx", 64'(bus.rk_idx), 64'h0);
        check("mid_rst_busy", 64'(bus.busy), 64'h0);
        check("mid_rst_sb_empty", 64'(sb.size()), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_key_ready", 64'(bus.key_ready), 64'h1);
        push_seq(1'b0, 16, 1'b0);
        send_key(KEY_A, 1'b0);
        wait_done(1'b0, 40);

        // One-round instance, both directions
        run_r1(1'b0);
        run_r1(1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'h0);
        check("sb1_drained", 64'(sb1.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
